// File: rtl/spi_frm_seq.sv
// spi_frm_seq: SCLK-domain frame sequencer in front of the SPI slave core.
// It tracks a fixed CMD_W+DATA_W+CRC_W bit frame bit by bit and flags short
// and long frames. Each complete frame is handed to the core domain through
// a toggle. It also loads the MISO slot for the next frame, taking the
// register response word when one is pending and the status word otherwise.
//
// Ports:
//   i_spi_sclk    SPI clock; rising edge samples MOSI, falling edge drives MISO
//   i_rst_n       asynchronous active-low reset
//   i_spi_csb     chip select (low active); high aborts the frame asynchronously
//   i_spi_mosi    serial data in
//   i_rsp_vld     register response pending
//   i_rsp_word    register response word
//   i_sts_word    fallback status word
//   o_spi_miso    serial data out, MSB first
//   o_frm_word    last complete received frame
//   o_frm_tgl     toggles once per complete frame
//   o_len_err_tgl toggles once per short or long frame
//   o_rsp_ack_tgl toggles when i_rsp_word is loaded into the slot
//   o_rsp_sel     1 = slot holds i_rsp_word, 0 = slot holds i_sts_word
//   o_state       FSM state for observation
module spi_frm_seq #(
    parameter int unsigned CMD_W  = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CRC_W  = 8,
    localparam int unsigned FRM_W = CMD_W + DATA_W + CRC_W,
    localparam int unsigned CNT_W = $clog2(FRM_W + 1)
) (
    input  logic             i_spi_sclk,
    input  logic             i_rst_n,
    input  logic             i_spi_csb,
    input  logic             i_spi_mosi,
    input  logic             i_rsp_vld,
    input  logic [FRM_W-1:0] i_rsp_word,
    input  logic [FRM_W-1:0] i_sts_word,
    output logic             o_spi_miso,
    output logic [FRM_W-1:0] o_frm_word,
    output logic             o_frm_tgl,
    output logic             o_len_err_tgl,
    output logic             o_rsp_ack_tgl,
    output logic             o_rsp_sel,
    output logic [2:0]       o_state
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_CRC  = 3'd3,
        ST_DONE = 3'd4,
        ST_OVF  = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_CMD  = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(CMD_W + DATA_W);
    localparam logic [CNT_W-1:0] CNT_FRM  = CNT_W'(FRM_W);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(FRM_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   miso_idx;
    logic [FRM_W-1:0]   rx_sr;
    logic [FRM_W-1:0]   rx_nxt;
    logic [FRM_W-1:0]   slot;
    logic               short_flg;
    logic               frm_rst_n;
    logic               frm_start;
    logic               frm_end;
    logic               ovf_start;

    // Frame-tracking state is reset by i_rst_n and also held idle while csb is high.
    assign frm_rst_n = i_rst_n & ~i_spi_csb;

    // Next-state, counter and event decode for the rising edge.
    always_comb begin
        state_nxt = state;
        cnt_inc   = (cnt == CNT_FRM) ? cnt : cnt + CNT_W'(1);
        rx_nxt    = {rx_sr[FRM_W-2:0], i_spi_mosi};
        miso_idx  = CNT_TOP - cnt;
        frm_start = (state == ST_IDLE);
        frm_end   = (state == ST_CRC) && (cnt_inc == CNT_FRM);
        ovf_start = (state == ST_DONE);
        unique case (state)
            ST_IDLE: state_nxt = ST_CMD;
            ST_CMD:  if (cnt_inc == CNT_CMD)  state_nxt = ST_DATA;
            ST_DATA: if (cnt_inc == CNT_DATA) state_nxt = ST_CRC;
            ST_CRC:  if (cnt_inc == CNT_FRM)  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_OVF;
            ST_OVF:  state_nxt = ST_OVF;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame FSM, bit counter and receive shift register.
    always_ff @(posedge i_spi_sclk or negedge frm_rst_n) begin
        if (!frm_rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rx_sr <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_inc;
            rx_sr <= rx_nxt;
        end
    end

    // Frame hand-off, length-error detection and slot arbitration; survives csb.
    always_ff @(posedge i_spi_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frm_word    <= '0;
            o_frm_tgl     <= 1'b0;
            o_len_err_tgl <= 1'b0;
            o_rsp_ack_tgl <= 1'b0;
            o_rsp_sel     <= 1'b0;
            slot          <= '0;
            short_flg     <= 1'b0;
        end else if (!i_spi_csb) begin
            if (frm_end) begin
                o_frm_word <= rx_nxt;
                o_frm_tgl  <= ~o_frm_tgl;
                if (i_rsp_vld) begin
                    slot          <= i_rsp_word;
                    o_rsp_sel     <= 1'b1;
                    o_rsp_ack_tgl <= ~o_rsp_ack_tgl;
                end else begin
                    slot      <= i_sts_word;
                    o_rsp_sel <= 1'b0;
                end
            end
            // A flag still set at the start of a frame means the previous one was cut short.
            if (ovf_start || (frm_start && short_flg)) begin
                o_len_err_tgl <= ~o_len_err_tgl;
            end
            if (frm_end) begin
                short_flg <= 1'b0;
            end else if (cnt_inc < CNT_FRM) begin
                short_flg <= 1'b1;
            end
        end
    end

    // MISO launched on the falling edge so the master can sample on the rising edge.
    always_ff @(negedge i_spi_sclk or negedge frm_rst_n) begin
        if (!frm_rst_n) begin
            o_spi_miso <= 1'b0;
        end else if ((state == ST_DONE) || (state == ST_OVF)) begin
            o_spi_miso <= 1'b0;
        end else begin
            o_spi_miso <= slot[miso_idx];
        end
    end

    assign o_state = 3'(state);

endmodule

// File: tb/tb_spi_frm_seq.sv
// Self-checking bench for spi_frm_seq: directed scenarios plus randomized
// frames, checked against a frame-level reference model.
module tb_spi_frm_seq;

    logic        sclk = 1'b1;
    logic        rst_n;
    logic        csb;
    logic        mosi;
    logic        rsp_vld;
    logic [23:0] rsp_word;
    logic [23:0] sts_word;
    logic        miso;
    logic [23:0] frm_word;
    logic        frm_tgl;
    logic        len_err_tgl;
    logic        rsp_ack_tgl;
    logic        rsp_sel;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    // Reference model: frame-level view of the observable results
    logic [23:0] m_slot;
    logic [23:0] m_frm_word;
    logic        m_frm_tgl;
    logic        m_len_tgl;
    logic        m_ack_tgl;
    logic        m_sel;
    logic        m_pend;

    spi_frm_seq dut (
        .i_spi_sclk    (sclk),
        .i_rst_n       (rst_n),
        .i_spi_csb     (csb),
        .i_spi_mosi    (mosi),
        .i_rsp_vld     (rsp_vld),
        .i_rsp_word    (rsp_word),
        .i_sts_word    (sts_word),
        .o_spi_miso    (miso),
        .o_frm_word    (frm_word),
        .o_frm_tgl     (frm_tgl),
        .o_len_err_tgl (len_err_tgl),
        .o_rsp_ack_tgl (rsp_ack_tgl),
        .o_rsp_sel     (rsp_sel),
        .o_state       (state)
    );

    always #5 sclk = ~sclk;

    task automatic model_reset();
        m_slot     = '0;
        m_frm_word = '0;
        m_frm_tgl  = 1'b0;
        m_len_tgl  = 1'b0;
        m_ack_tgl  = 1'b0;
        m_sel      = 1'b0;
        m_pend     = 1'b0;
    endtask

    // Send an n-bit frame (bits[n-1] first) and check every observable step.
    task automatic send_frame(input int n, input logic [31:0] bits);
        logic [23:0] cur_slot;
        logic [23:0] acc;
        logic        exp_bit;
        cur_slot = m_slot;
        acc      = '0;
        @(posedge sclk); #1;
        csb = 1'b0;
        for (int i = 0; i < n; i++) begin
            mosi = bits[n-1-i];
            @(negedge sclk); #1;
            exp_bit = (i < 24) ? cur_slot[23-i] : 1'b0;
            checks++;
            if (miso !== exp_bit) begin
                errors++;
                $display("FAIL miso bit %0d: got %b expected %b", i, miso, exp_bit);
            end
            @(posedge sclk); #1;
            if (i < 24) acc = {acc[22:0], mosi};
            if (i == 0) begin
                if (m_pend) m_len_tgl = ~m_len_tgl;
                m_pend = 1'b0;
                checks++;
                if (len_err_tgl !== m_len_tgl) begin
                    errors++;
                    $display("FAIL len_err_tgl at frame start: got %b expected %b", len_err_tgl, m_len_tgl);
                end
            end
            if (i == 23) begin
                m_frm_word = acc;
                m_frm_tgl  = ~m_frm_tgl;
                if (rsp_vld) begin
                    m_slot    = rsp_word;
                    m_sel     = 1'b1;
                    m_ack_tgl = ~m_ack_tgl;
                end else begin
                    m_slot = sts_word;
                    m_sel  = 1'b0;
                end
                checks++;
                if ({frm_word, frm_tgl, rsp_sel, rsp_ack_tgl} !== {m_frm_word, m_frm_tgl, m_sel, m_ack_tgl}) begin
                    errors++;
                    $display("FAIL frame end: got word=%h tgl=%b sel=%b ack=%b expected word=%h tgl=%b sel=%b ack=%b",
                             frm_word, frm_tgl, rsp_sel, rsp_ack_tgl, m_frm_word, m_frm_tgl, m_sel, m_ack_tgl);
                end
            end
            if (i == 24) m_len_tgl = ~m_len_tgl;
        end
        if (n >= 1 && n < 24) m_pend = 1'b1;
        if (n >= 24) begin
            checks++;
            if (state !== ((n == 24) ? 3'd4 : 3'd5)) begin
                errors++;
                $display("FAIL state before csb rise (n=%0d): got %0d expected %0d", n, state, (n == 24) ? 4 : 5);
            end
        end
        csb = 1'b1;
        #1;
        checks++;
        if ({state, miso} !== {3'd0, 1'b0}) begin
            errors++;
            $display("FAIL idle after csb: got state=%0d miso=%b expected state=0 miso=0", state, miso);
        end
        @(posedge sclk); #1;
        checks++;
        if ({frm_word, frm_tgl, len_err_tgl, rsp_ack_tgl, rsp_sel} !==
            {m_frm_word, m_frm_tgl, m_len_tgl, m_ack_tgl, m_sel}) begin
            errors++;
            $display("FAIL after frame (n=%0d): got word=%h frm=%b len=%b ack=%b sel=%b expected word=%h frm=%b len=%b ack=%b sel=%b",
                     n, frm_word, frm_tgl, len_err_tgl, rsp_ack_tgl, rsp_sel,
                     m_frm_word, m_frm_tgl, m_len_tgl, m_ack_tgl, m_sel);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; csb = 1'b1; mosi = 1'b0;
        rsp_vld = 1'b0; rsp_word = '0; sts_word = '0;
        model_reset();
        repeat (3) @(posedge sclk);
        #1;
        checks++;
        if ({miso, frm_word, frm_tgl, len_err_tgl, rsp_ack_tgl, rsp_sel, state} !== 31'd0) begin
            errors++;
            $display("FAIL reset outputs: got miso=%b word=%h frm=%b len=%b ack=%b sel=%b state=%0d expected all 0",
                     miso, frm_word, frm_tgl, len_err_tgl, rsp_ack_tgl, rsp_sel, state);
        end
        rst_n = 1'b1;
        @(posedge sclk); #1;
    endtask

    task automatic test_basic_frame();
        rsp_vld  = 1'b0;
        sts_word = 24'h00F00F;
        send_frame(24, 32'h00815AC3);
    endtask

    task automatic test_rsp_priority();
        rsp_vld  = 1'b1;
        rsp_word = 24'hA51234;
        send_frame(24, 32'h00123456);
        rsp_vld  = 1'b0;
        sts_word = 24'h3C3C3C;
        send_frame(24, 32'h00ABCDEF);
    endtask

    task automatic test_long_frame();
        send_frame(27, 32'h05A5A5A5);
    endtask

    task automatic test_short_frame();
        send_frame(13, 32'h00001ABC);
        send_frame(24, 32'h00C0FFEE);
    endtask

    task automatic test_reset_mid_frame();
        @(posedge sclk); #1;
        csb = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom);
            @(posedge sclk); #1;
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({miso, frm_word, frm_tgl, len_err_tgl, rsp_ack_tgl, rsp_sel, state} !== 31'd0) begin
            errors++;
            $display("FAIL mid-frame reset: got miso=%b word=%h frm=%b len=%b ack=%b sel=%b state=%0d expected all 0",
                     miso, frm_word, frm_tgl, len_err_tgl, rsp_ack_tgl, rsp_sel, state);
        end
        csb = 1'b1;
        @(posedge sclk); #1;
        rst_n = 1'b1;
        @(posedge sclk); #1;
        send_frame(24, 32'h00135799);
    endtask

    task automatic test_random();
        int          n;
        logic [31:0] bits;
        for (int k = 0; k < 30; k++) begin
            n        = ($urandom_range(0, 3) < 2) ? 24 : int'($urandom_range(1, 30));
            bits     = $urandom;
            rsp_vld  = 1'($urandom_range(0, 1));
            rsp_word = 24'($urandom);
            sts_word = 24'($urandom);
            send_frame(n, bits);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_rsp_priority();
        test_long_frame();
        test_short_frame();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
